// File: rtl/pb_debounce_array.sv
// Multi-channel pushbutton conditioner: per channel sync, debounce, polarity fix,
// plus one-cycle press / release / long-press pulses.
module pb_debounce_array #(
  parameter int unsigned     N_CH            = 5,
  parameter int unsigned     DEBOUNCE_PERIOD = 1000000,
  parameter int unsigned     LONG_PERIOD     = 50000000,
  parameter logic [N_CH-1:0] POLARITY        = {N_CH{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long,
  output logic            any_active
);

  localparam int unsigned       DCNT_W    = $clog2(DEBOUNCE_PERIOD + 1);
  localparam int unsigned       HCNT_W    = (LONG_PERIOD > 0) ? $clog2(LONG_PERIOD + 1) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_PERIOD - 1);

  logic [N_CH-1:0] raw;
  assign raw        = btn_in ^ POLARITY;
  assign any_active = |btn_level;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic              s1;
    logic              s2;
    logic              level_q;
    logic              press_q;
    logic              rel_q;
    logic [DCNT_W-1:0] dcnt;
    logic              accept;

    // A change is accepted once s2 has disagreed with the level for DEBOUNCE_PERIOD edges.
    assign accept = (s2 != level_q) && (dcnt == DCNT_LAST);

    always_ff @(posedge clk) begin
      if (reset) begin
        s1      <= 1'b0;
        s2      <= 1'b0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        dcnt    <= '0;
      end else begin
        s1      <= raw[i];
        s2      <= s1;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        if (s2 == level_q) begin
          dcnt <= '0;
        end else if (accept) begin
          level_q <= s2;
          dcnt    <= '0;
          press_q <= s2;
          rel_q   <= ~s2;
        end else begin
          dcnt <= dcnt + DCNT_W'(1);
        end
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;

    if (LONG_PERIOD > 0) begin : g_long
      localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(LONG_PERIOD);
      logic [HCNT_W-1:0] hcnt;
      logic              long_q;

      // Hold counter saturates at terminal count so the pulse fires once per press;
      // a release accepted on the terminal edge suppresses it.
      always_ff @(posedge clk) begin
        if (reset) begin
          hcnt   <= '0;
          long_q <= 1'b0;
        end else begin
          long_q <= 1'b0;
          if (!level_q) begin
            hcnt <= '0;
          end else if (hcnt != HCNT_MAX) begin
            hcnt <= hcnt + HCNT_W'(1);
            if ((hcnt == HCNT_MAX - HCNT_W'(1)) && !accept) long_q <= 1'b1;
          end
        end
      end

      assign btn_long[i] = long_q;
    end else begin : g_nolong
      assign btn_long[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_pb_debounce_array.sv
// Directed bench for pb_debounce_array: cycle-exact vector table plus
// hand sequences for bounce, long press and release/long-press tie.
module tb_pb_debounce_array;

  localparam logic [4:0] POL  = 5'b10000;
  localparam logic [4:0] IDLE = 5'b10000;
  localparam logic [4:0] P34  = 5'b01000;
  localparam logic [4:0] B34  = 5'b11000;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_in;
  logic [4:0] btn_level, btn_press, btn_release, btn_long;
  logic       any_active;

  always #5 clk = ~clk;

  pb_debounce_array #(
    .N_CH(5), .DEBOUNCE_PERIOD(4), .LONG_PERIOD(20), .POLARITY(POL)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .any_active(any_active)
  );

  typedef struct {
    logic       rst;
    logic [4:0] in;
    logic [4:0] lvl;
    logic [4:0] prs;
    logic [4:0] rel;
    logic [4:0] lng;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  // Pulse monitor: counts and cycle stamps per channel, sampled after each edge.
  int cyc = 0;
  int np[5], nr[5], nl[5], tp[5], tr[5], tl[5];

  always @(posedge clk) begin
    #2;
    cyc++;
    for (int ch = 0; ch < 5; ch++) begin
      if (btn_press[ch] === 1'b1)   begin np[ch]++; tp[ch] = cyc; end
      if (btn_release[ch] === 1'b1) begin nr[ch]++; tr[ch] = cyc; end
      if (btn_long[ch] === 1'b1)    begin nl[ch]++; tl[ch] = cyc; end
    end
  end

  function automatic void add(logic rst, logic [4:0] in, logic [4:0] lvl,
                              logic [4:0] prs, logic [4:0] rel, logic [4:0] lng);
    vec_t v;
    v.rst = rst; v.in = in; v.lvl = lvl; v.prs = prs; v.rel = rel; v.lng = lng;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clr();
    for (int ch = 0; ch < 5; ch++) begin
      np[ch] = 0; nr[ch] = 0; nl[ch] = 0; tp[ch] = 0; tr[ch] = 0; tl[ch] = 0;
    end
  endtask

  // Press ch2, let the level stay high for gap cycles, then release.
  task automatic hold_gap(input int gap, input int exp_long);
    int c;
    clr();
    c = cyc;
    btn_in[2] = 1'b1;
    repeat (gap) @(negedge clk);
    btn_in[2] = 1'b0;
    repeat (10) @(negedge clk);
    check($sformatf("gap%0d_press_lat", gap), 32'(tp[2] - c), 32'd6);
    check($sformatf("gap%0d_press_cnt", gap), 32'(np[2]), 32'd1);
    check($sformatf("gap%0d_rel_cnt", gap), 32'(nr[2]), 32'd1);
    check($sformatf("gap%0d_rel_gap", gap), 32'(tr[2] - tp[2]), 32'(gap));
    check($sformatf("gap%0d_long_cnt", gap), 32'(nl[2]), 32'(exp_long));
  endtask

  initial begin
    int c;
    reset  = 1'b1;
    btn_in = IDLE;
    clr();

    // Reset and idle: nothing may move
    repeat (3)  add(1'b1, IDLE, 5'b0, 5'b0, 5'b0, 5'b0);
    repeat (20) add(1'b0, IDLE, 5'b0, 5'b0, 5'b0, 5'b0);
    // Clean press and release of ch0
    repeat (5)  add(1'b0, 5'b10001, 5'b0, 5'b0, 5'b0, 5'b0);
    add(1'b0, 5'b10001, 5'b00001, 5'b00001, 5'b0, 5'b0);
    repeat (2)  add(1'b0, 5'b10001, 5'b00001, 5'b0, 5'b0, 5'b0);
    repeat (5)  add(1'b0, IDLE, 5'b00001, 5'b0, 5'b0, 5'b0);
    add(1'b0, IDLE, 5'b0, 5'b0, 5'b00001, 5'b0);
    repeat (2)  add(1'b0, IDLE, 5'b0, 5'b0, 5'b0, 5'b0);
    // Simultaneous press of ch3 and active-low ch4, then release
    repeat (5)  add(1'b0, P34, 5'b0, 5'b0, 5'b0, 5'b0);
    add(1'b0, P34, B34, B34, 5'b0, 5'b0);
    add(1'b0, P34, B34, 5'b0, 5'b0, 5'b0);
    repeat (5)  add(1'b0, IDLE, B34, 5'b0, 5'b0, 5'b0);
    add(1'b0, IDLE, 5'b0, 5'b0, B34, 5'b0);
    add(1'b0, IDLE, 5'b0, 5'b0, 5'b0, 5'b0);
    // Reset at edge 4 of a pending press restarts the count
    repeat (3)  add(1'b0, P34, 5'b0, 5'b0, 5'b0, 5'b0);
    add(1'b1, P34, 5'b0, 5'b0, 5'b0, 5'b0);
    repeat (5)  add(1'b0, P34, 5'b0, 5'b0, 5'b0, 5'b0);
    add(1'b0, P34, B34, B34, 5'b0, 5'b0);
    // Reset during the pulse: pulse cleared, no release, fresh press later
    add(1'b1, P34, 5'b0, 5'b0, 5'b0, 5'b0);
    repeat (5)  add(1'b0, P34, 5'b0, 5'b0, 5'b0, 5'b0);
    add(1'b0, P34, B34, B34, 5'b0, 5'b0);
    add(1'b0, P34, B34, 5'b0, 5'b0, 5'b0);
    repeat (5)  add(1'b0, IDLE, B34, 5'b0, 5'b0, 5'b0);
    add(1'b0, IDLE, 5'b0, 5'b0, B34, 5'b0);
    add(1'b0, IDLE, 5'b0, 5'b0, 5'b0, 5'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset  = tbl[i].rst;
      btn_in = tbl[i].in;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            32'({btn_level, btn_press, btn_release, btn_long, any_active}),
            32'({tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].lng, |tbl[i].lvl}));
    end

    reset  = 1'b0;
    btn_in = IDLE;
    repeat (2) @(negedge clk);

    // Bounce on ch1: 3-cycle runs never satisfy a 4-cycle debounce
    clr();
    for (int k = 0; k < 10; k++) begin
      btn_in[1] = (k % 2 == 0);
      repeat (3) @(negedge clk);
    end
    check("bounce_no_press", 32'(np[1]), 32'd0);
    c = cyc;
    btn_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    check("bounce_press_cnt", 32'(np[1]), 32'd1);
    check("bounce_press_lat", 32'(tp[1] - c), 32'd6);
    btn_in[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("bounce_rel_cnt", 32'(nr[1]), 32'd1);

    // Long press on ch2: one long pulse 20 cycles after press, never repeated
    clr();
    c = cyc;
    btn_in[2] = 1'b1;
    repeat (60) @(negedge clk);
    check("long_press_cnt", 32'(np[2]), 32'd1);
    check("long_press_lat", 32'(tp[2] - c), 32'd6);
    check("long_cnt", 32'(nl[2]), 32'd1);
    check("long_lat", 32'(tl[2] - tp[2]), 32'd20);
    check("long_level", 32'(btn_level), 32'h04);
    c = cyc;
    btn_in[2] = 1'b0;
    repeat (10) @(negedge clk);
    check("long_rel_cnt", 32'(nr[2]), 32'd1);
    check("long_rel_lat", 32'(tr[2] - c), 32'd6);
    check("long_no_repeat", 32'(nl[2]), 32'd1);

    // Short hold, release on the terminal edge (release wins), one cycle longer
    hold_gap(15, 0);
    hold_gap(20, 0);
    hold_gap(21, 1);
    check("gap21_long_lat", 32'(tl[2] - tp[2]), 32'd20);
    check("final_idle", 32'({btn_level, any_active}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
